shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 19 +
 rtl/shifter.sv | 21 ++
 rtl/shift_sequencer.sv | 84 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shifter.sv
// Combinational single-bit shift step.
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] shift_in,
  input  shift_op_t         shift_op,
  output logic [DATA_W-1:0] shift_out
);

  always_comb begin
    shift_out = shift_in;
    case (shift_op)
      SH_NONE: shift_out = shift_in;
      SH_LSL:  shift_out = {shift_in[DATA_W-2:0], 1'b0};
      SH_LSR:  shift_out = {1'b0, shift_in[DATA_W-1:1]};
      SH_ASR:  shift_out = {shift_in[DATA_W-1], shift_in[DATA_W-1:1]};
      default: shift_out = shift_in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies one single-bit step per cycle, amount times.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        op,
  input  logic [3:0]        amount,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output seq_state_t        dbg_state
);

  // Request handshake: start is accepted only on an edge where busy is low
  // (state IDLE); while busy is high start is dropped, never queued.

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  shift_op_t         op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] step_out;

  shifter u_shifter (
    .shift_in  (work_q),
    .shift_op  (op_q),
    .shift_out (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= SH_NONE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = in;
          op_d    = shift_op_t'(op);
          cnt_d   = amount;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Counter reaching zero costs one extra cycle to publish the result.
        if (cnt_q != 4'd0) begin
          work_d = step_out;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          out_d   = work_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out       = out_q;
  assign dbg_state = state_q;

endmodule
